// File: rtl/guitar_judge.sv
// rtl/guitar_judge.sv - strum debounce, timed hit window, score/streak/multiplier keeper
// Optional miss penalty enabled by defining GUITAR_MISS_PENALTY_EN.
module guitar_judge #(
    parameter int LANES           = 4,
    parameter int SCORE_W         = 32,
    parameter int DEBOUNCE        = 16,
    parameter int WINDOW          = 8,
    parameter int MAX_MULT        = 4,
    parameter int STREAK_PER_MULT = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               strum,
    input  logic [LANES-1:0]   buttons,
    input  logic [LANES-1:0]   intersections,
    input  logic [31:0]        mw_ir,
    output logic               update,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic [2:0]         mult,
    output logic               score_out
);
    localparam int DW = $clog2(DEBOUNCE);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int PW = $clog2(STREAK_PER_MULT + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [PW-1:0] PROG_LAST = PW'(STREAK_PER_MULT - 1);
    localparam logic [2:0]    MULT_TOP  = 3'(MAX_MULT);

    typedef enum logic {IDLE, JUDGE} state_t;

    logic               s1_q, s_sync_q;
    logic               db_q, db_d, db_prev_q;
    logic [DW-1:0]      db_cnt_q, db_cnt_d;
    state_t             state_q, state_d;
    logic [WW-1:0]      win_q, win_d;
    logic               hit_q, hit_d, miss_q, miss_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   sum;
    logic [7:0]         streak_q, streak_d;
    logic [2:0]         mult_q, mult_d;
    logic [PW-1:0]      prog_q, prog_d;
    logic               match;
    logic               unused_ir_bits;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (s_sync_q == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = s_sync_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    assign update = db_q & ~db_prev_q;
    assign match  = (buttons == intersections) && (intersections != '0);

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        score_d  = score_q;
        streak_d = streak_q;
        mult_d   = mult_q;
        prog_d   = prog_q;
        sum      = {1'b0, score_q} + (SCORE_W + 1)'(mult_q);
        case (state_q)
            IDLE: begin
                if (update) begin
                    state_d = JUDGE;
                    win_d   = WIN_LAST;
                end
            end
            JUDGE: begin
                if (match) begin
                    state_d  = IDLE;
                    hit_d    = 1'b1;
                    score_d  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                    streak_d = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
                    if (prog_q == PROG_LAST) begin
                        prog_d = '0;
                        mult_d = (mult_q >= MULT_TOP) ? MULT_TOP : mult_q + 3'd1;
                    end else begin
                        prog_d = prog_q + PW'(1);
                    end
                end else if (win_q == '0) begin
                    state_d  = IDLE;
                    miss_d   = 1'b1;
                    streak_d = '0;
                    prog_d   = '0;
                    mult_d   = 3'd1;
`ifdef GUITAR_MISS_PENALTY_EN
                    if (score_q != '0) score_d = score_q - SCORE_W'(1);
`endif
                end else begin
                    win_d = win_q - WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s_sync_q  <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            win_q     <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            score_q   <= '0;
            streak_q  <= '0;
            mult_q    <= 3'd1;
            prog_q    <= '0;
        end else begin
            s1_q      <= strum;
            s_sync_q  <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            win_q     <= win_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            score_q   <= score_d;
            streak_q  <= streak_d;
            mult_q    <= mult_d;
            prog_q    <= prog_d;
        end
    end

    assign hit    = hit_q;
    assign miss   = miss_q;
    assign score  = score_q;
    assign streak = streak_q;
    assign mult   = mult_q;

    // Only the destination-register field matters for the r28 writeback flag.
    assign score_out      = (mw_ir[26:22] == 5'd28);
    assign unused_ir_bits = ^{mw_ir[31:27], mw_ir[21:0]};
endmodule
